// File: rtl/tlcd_bus_arbiter_pkg.sv
// Shared definitions for the text LCD bus: sequencer states, command
// classification and default timing shared by all LCD bus requesters.
package tlcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_E_HIGH,
    ST_HOLD,
    ST_EXEC
  } tlcd_state_t;

  localparam int unsigned TLCD_T_SETUP_DEF     = 2;
  localparam int unsigned TLCD_T_E_HIGH_DEF    = 12;
  localparam int unsigned TLCD_T_HOLD_DEF      = 2;
  localparam int unsigned TLCD_T_EXEC_DEF      = 50;
  localparam int unsigned TLCD_T_EXEC_LONG_DEF = 2000;

  // Clear display (0x01) and return home (0x02) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return (rs == 1'b0) && ((data == 8'h01) || (data == 8'h02));
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/tlcd_bus_arbiter_if.sv
// Request-side handshake bundle between the two LCD requesters and the arbiter.
// Index 0 is the font loader, index 1 the text controller.
interface tlcd_bus_arbiter_if;
  logic [1:0]  req_valid;
  logic [1:0]  req_rs;
  logic [15:0] req_data;
  logic [1:0]  req_lock;
  logic [1:0]  req_ready;
  logic [1:0]  req_done;

  modport master (
    output req_valid, req_rs, req_data, req_lock,
    input  req_ready, req_done
  );

  modport slave (
    input  req_valid, req_rs, req_data, req_lock,
    output req_ready, req_done
  );
endinterface

// File: rtl/tlcd_bus_arbiter_lcd_phase_timer.sv
// Loadable down-counter timing each LCD bus phase; zero marks the last cycle.
module lcd_phase_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RESETN,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] cnt;

  // Load on phase entry, otherwise count down and rest at zero.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign zero = (cnt == '0);

endmodule

// File: rtl/tlcd_bus_arbiter.sv
// Command-level arbiter and E-strobe sequencer for the shared 16x2 LCD pins.
// Grants one byte write at a time, sequences setup/E-high/hold/exec, then
// pulses done to the owner.
module tlcd_bus_arbiter
  import tlcd_pkg::*;
#(
  parameter int unsigned T_SETUP_CYC     = TLCD_T_SETUP_DEF,
  parameter int unsigned T_E_HIGH_CYC    = TLCD_T_E_HIGH_DEF,
  parameter int unsigned T_HOLD_CYC      = TLCD_T_HOLD_DEF,
  parameter int unsigned T_EXEC_CYC      = TLCD_T_EXEC_DEF,
  parameter int unsigned T_EXEC_LONG_CYC = TLCD_T_EXEC_LONG_DEF
) (
  input  logic               CLK,
  input  logic               RESETN,
  tlcd_bus_arbiter_if.slave  bus,
  output logic               TLCD_E,
  output logic               TLCD_RS,
  output logic               TLCD_RW,
  output logic [7:0]         TLCD_DATA,
  output logic               busy,
  output logic               owner
);

  localparam int unsigned T_MAX = max2(max2(max2(T_SETUP_CYC, T_E_HIGH_CYC),
                                            max2(T_HOLD_CYC, T_EXEC_CYC)),
                                       T_EXEC_LONG_CYC);
  localparam int unsigned CNT_W = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] LD_SETUP     = CNT_W'(T_SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] LD_E_HIGH    = CNT_W'(T_E_HIGH_CYC - 1);
  localparam logic [CNT_W-1:0] LD_HOLD      = CNT_W'(T_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC      = CNT_W'(T_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] LD_EXEC_LONG = CNT_W'(T_EXEC_LONG_CYC - 1);

  if (T_SETUP_CYC == 0 || T_E_HIGH_CYC == 0 || T_HOLD_CYC == 0 ||
      T_EXEC_CYC == 0 || T_EXEC_LONG_CYC == 0) begin : g_param_check
    $error("tlcd_bus_arbiter: all timing parameters must be nonzero");
  end

  tlcd_state_t      state;
  logic             lock_q;
  logic             last_win;
  logic             long_q;
  logic [1:0]       done_q;

  logic [1:0]       elig;
  logic [1:0]       grant;
  logic             win;
  logic             accept;
  logic             win_rs;
  logic             win_lock;
  logic [7:0]       win_data;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_zero;

  // Pick the winner: lock restricts to the owner, ties alternate.
  always_comb begin
    elig  = bus.req_valid;
    grant = 2'b00;
    win   = 1'b0;
    if (lock_q) begin
      elig = bus.req_valid & (owner ? 2'b10 : 2'b01);
    end
    case (elig)
      2'b01: begin
        win   = 1'b0;
        grant = 2'b01;
      end
      2'b10: begin
        win   = 1'b1;
        grant = 2'b10;
      end
      2'b11: begin
        win   = ~last_win;
        grant = last_win ? 2'b01 : 2'b10;
      end
      default: begin
        win   = 1'b0;
        grant = 2'b00;
      end
    endcase
  end

  assign bus.req_ready = (state == ST_IDLE) ? grant : 2'b00;
  assign accept        = |bus.req_ready;
  assign win_rs        = bus.req_rs[win];
  assign win_lock      = bus.req_lock[win];
  assign win_data      = win ? bus.req_data[15:8] : bus.req_data[7:0];
  assign bus.req_done  = done_q;
  assign TLCD_RW       = 1'b0;

  // Reload the phase timer on entry to each phase.
  always_comb begin
    tmr_load = 1'b0;
    tmr_val  = '0;
    case (state)
      ST_IDLE: begin
        tmr_load = accept;
        tmr_val  = LD_SETUP;
      end
      ST_SETUP: begin
        tmr_load = tmr_zero;
        tmr_val  = LD_E_HIGH;
      end
      ST_E_HIGH: begin
        tmr_load = tmr_zero;
        tmr_val  = LD_HOLD;
      end
      ST_HOLD: begin
        tmr_load = tmr_zero;
        tmr_val  = long_q ? LD_EXEC_LONG : LD_EXEC;
      end
      default: begin
        tmr_load = 1'b0;
        tmr_val  = '0;
      end
    endcase
  end

  lcd_phase_timer #(.CNT_W(CNT_W)) u_timer (
    .CLK      (CLK),
    .RESETN   (RESETN),
    .load     (tmr_load),
    .load_val (tmr_val),
    .zero     (tmr_zero)
  );

  // Bus sequencer; the RS/DATA pin registers double as the command capture.
  always_ff @(posedge CLK or negedge RESETN) begin
    if (!RESETN) begin
      state     <= ST_IDLE;
      lock_q    <= 1'b0;
      last_win  <= 1'b1;
      long_q    <= 1'b0;
      owner     <= 1'b0;
      busy      <= 1'b0;
      done_q    <= 2'b00;
      TLCD_E    <= 1'b0;
      TLCD_RS   <= 1'b0;
      TLCD_DATA <= '0;
    end else begin
      done_q <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state     <= ST_SETUP;
            owner     <= win;
            last_win  <= win;
            lock_q    <= win_lock;
            long_q    <= is_long_cmd(win_rs, win_data);
            TLCD_RS   <= win_rs;
            TLCD_DATA <= win_data;
            busy      <= 1'b1;
          end
        end
        ST_SETUP: begin
          if (tmr_zero) begin
            state  <= ST_E_HIGH;
            TLCD_E <= 1'b1;
          end
        end
        ST_E_HIGH: begin
          if (tmr_zero) begin
            state  <= ST_HOLD;
            TLCD_E <= 1'b0;
          end
        end
        ST_HOLD: begin
          if (tmr_zero) begin
            state     <= ST_EXEC;
            TLCD_RS   <= 1'b0;
            TLCD_DATA <= '0;
          end
        end
        ST_EXEC: begin
          if (tmr_zero) begin
            state  <= ST_IDLE;
            busy   <= 1'b0;
            done_q <= owner ? 2'b10 : 2'b01;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tlcd_bus_arbiter.sv
// Scoreboard bench for tlcd_bus_arbiter: directed commands push expected
// grants/latencies; a negedge monitor checks grants, pin timing and done.
module tb_tlcd_bus_arbiter;

  logic       CLK = 1'b0;
  logic       RESETN = 1'b0;
  logic       TLCD_E, TLCD_RS, TLCD_RW, busy, owner;
  logic [7:0] TLCD_DATA;

  always #5 CLK = ~CLK;

  tlcd_bus_arbiter_if bus();

  tlcd_bus_arbiter #(
    .T_SETUP_CYC     (2),
    .T_E_HIGH_CYC    (12),
    .T_HOLD_CYC      (2),
    .T_EXEC_CYC      (50),
    .T_EXEC_LONG_CYC (2000)
  ) dut (
    .CLK       (CLK),
    .RESETN    (RESETN),
    .bus       (bus),
    .TLCD_E    (TLCD_E),
    .TLCD_RS   (TLCD_RS),
    .TLCD_RW   (TLCD_RW),
    .TLCD_DATA (TLCD_DATA),
    .busy      (busy),
    .owner     (owner)
  );

  typedef struct {
    int         req;
    logic       rs;
    logic [7:0] data;
    int         lat;
    int         gap;
    logic [1:0] rdy_at_done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   ecnt = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge CLK) ecnt <= ecnt + 1;

  // Monitor / scoreboard
  exp_t cur;
  logic cur_v = 1'b0;
  int   acc_edge = 0;
  int   prev_acc = -1;
  logic win_err = 1'b0;

  always @(negedge CLK) begin : mon
    int         p;
    int         o;
    logic       exp_e;
    logic       exp_rs;
    logic [7:0] exp_d;
    p = ecnt + 1;
    if (!RESETN) begin
      cur_v    = 1'b0;
      prev_acc = -1;
    end else begin
      if (cur_v) begin
        o = p - acc_edge;
        if (bus.req_done != 2'b00 || o >= cur.lat) begin
          chk("done_req", bus.req_done, cur.req ? 2 : 1);
          chk("done_latency", o, cur.lat);
          chk("phase_window", win_err, 0);
          chk("idle_pins", {TLCD_E, TLCD_RS, TLCD_DATA, busy}, 0);
          chk("ready_at_done", bus.req_ready, cur.rdy_at_done);
          cur_v = 1'b0;
        end else begin
          exp_e  = (o >= 3) && (o <= 14);
          exp_rs = (o <= 16) ? cur.rs : 1'b0;
          exp_d  = (o <= 16) ? cur.data : 8'h00;
          if (TLCD_E != exp_e || TLCD_RS != exp_rs || TLCD_DATA != exp_d ||
              busy != 1'b1 || TLCD_RW != 1'b0 || bus.req_ready != 2'b00)
            win_err = 1'b1;
          if (o == 1) chk("owner", owner, cur.req);
        end
      end else if (bus.req_done != 2'b00) begin
        chk("unexpected_done", bus.req_done, 0);
      end
      if ((bus.req_ready & bus.req_valid) != 2'b00) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_accept", bus.req_ready, 0);
        end else begin
          cur = exp_q.pop_front();
          chk("grant", bus.req_ready, cur.req ? 2 : 1);
          if (cur.gap != 0) chk("accept_gap", p - prev_acc, cur.gap);
          prev_acc = p;
          acc_edge = p;
          cur_v    = 1'b1;
          win_err  = 1'b0;
        end
      end
    end
  end

  task automatic expect_cmd(input int r, input logic rs, input logic [7:0] d,
                            input int lat, input int gap, input logic [1:0] rd);
    exp_t e;
    e = '{req: r, rs: rs, data: d, lat: lat, gap: gap, rdy_at_done: rd};
    exp_q.push_back(e);
  endtask

  // Present one command and hold valid until it is accepted.
  task automatic send1(input int r, input logic rs, input logic [7:0] d, input logic lk);
    bus.req_rs[r]   = rs;
    bus.req_lock[r] = lk;
    if (r == 0) bus.req_data[7:0] = d;
    else        bus.req_data[15:8] = d;
    bus.req_valid[r] = 1'b1;
    for (int i = 0; i < 5000; i++) begin
      @(negedge CLK);
      if (bus.req_ready[r]) begin
        @(posedge CLK);
        #1;
        return;
      end
    end
    chk($sformatf("accept_timeout_r%0d", r), bus.req_ready[r], 1);
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 6000; i++) begin
      @(negedge CLK);
      if (exp_q.size() == 0 && !cur_v) break;
    end
    chk("drain", exp_q.size() + int'(cur_v), 0);
  endtask

  task automatic do_reset();
    bus.req_valid = '0;
    bus.req_rs    = '0;
    bus.req_lock  = '0;
    bus.req_data  = '0;
    RESETN = 1'b0;
    repeat (2) @(posedge CLK);
    #1;
    RESETN = 1'b1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got timeout expected completion");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    bus.req_valid = '0;
    bus.req_rs    = '0;
    bus.req_lock  = '0;
    bus.req_data  = '0;
    RESETN = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("rst_E", TLCD_E, 0);
    chk("rst_RS", TLCD_RS, 0);
    chk("rst_RW", TLCD_RW, 0);
    chk("rst_DATA", TLCD_DATA, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_ready", bus.req_ready, 0);
    chk("rst_done", bus.req_done, 0);
    RESETN = 1'b1;
    @(posedge CLK);
    #1;

    // Single command from requester 0
    expect_cmd(0, 1'b1, 8'h41, 67, 0, 2'b00);
    send1(0, 1'b1, 8'h41, 1'b0);
    bus.req_valid[0] = 1'b0;
    wait_idle();

    // Tie after reset: strict alternation starting with requester 0
    do_reset();
    expect_cmd(0, 1'b1, 8'h10, 67, 0,  2'b10);
    expect_cmd(1, 1'b1, 8'h20, 67, 67, 2'b01);
    expect_cmd(0, 1'b1, 8'h11, 67, 67, 2'b10);
    expect_cmd(1, 1'b1, 8'h21, 67, 67, 2'b00);
    fork
      begin
        send1(0, 1'b1, 8'h10, 1'b0);
        send1(0, 1'b1, 8'h11, 1'b0);
        bus.req_valid[0] = 1'b0;
      end
      begin
        send1(1, 1'b1, 8'h20, 1'b0);
        send1(1, 1'b1, 8'h21, 1'b0);
        bus.req_valid[1] = 1'b0;
      end
    join
    wait_idle();

    // Lock: requester 1 waits through 8 locked commands plus the unlocking one
    do_reset();
    for (int i = 0; i < 9; i++)
      expect_cmd(0, 1'b0, 8'(8'h30 + i), 67, (i == 0) ? 0 : 67,
                 (i < 8) ? 2'b01 : 2'b10);
    expect_cmd(1, 1'b1, 8'h50, 67, 67, 2'b00);
    fork
      begin
        for (int i = 0; i < 9; i++)
          send1(0, 1'b0, 8'(8'h30 + i), (i < 8) ? 1'b1 : 1'b0);
        bus.req_valid[0] = 1'b0;
      end
      begin
        send1(1, 1'b1, 8'h50, 1'b0);
        bus.req_valid[1] = 1'b0;
      end
    join
    wait_idle();

    // Long commands versus the same byte as data
    do_reset();
    expect_cmd(0, 1'b0, 8'h01, 2017, 0,    2'b01);
    expect_cmd(0, 1'b1, 8'h01, 67,   2017, 2'b01);
    expect_cmd(0, 1'b0, 8'h02, 2017, 67,   2'b00);
    send1(0, 1'b0, 8'h01, 1'b0);
    send1(0, 1'b1, 8'h01, 1'b0);
    send1(0, 1'b0, 8'h02, 1'b0);
    bus.req_valid[0] = 1'b0;
    wait_idle();

    // Reset during E high: immediate clear, no done, fresh round-robin
    do_reset();
    expect_cmd(0, 1'b1, 8'h77, 67, 0, 2'b00);
    send1(0, 1'b1, 8'h77, 1'b0);
    bus.req_valid[0] = 1'b0;
    repeat (5) @(posedge CLK);
    #3;
    chk("e_before_reset", TLCD_E, 1);
    RESETN = 1'b0;
    #1;
    chk("async_E", TLCD_E, 0);
    chk("async_DATA", TLCD_DATA, 0);
    chk("async_RS", TLCD_RS, 0);
    chk("async_busy", busy, 0);
    chk("async_done", bus.req_done, 0);
    repeat (2) @(posedge CLK);
    #1;
    RESETN = 1'b1;
    repeat (100) @(posedge CLK);
    #1;
    chk("abort_no_pending", exp_q.size() + int'(cur_v), 0);
    expect_cmd(0, 1'b1, 8'h5A, 67, 0,  2'b10);
    expect_cmd(1, 1'b1, 8'hA5, 67, 67, 2'b00);
    fork
      begin
        send1(0, 1'b1, 8'h5A, 1'b0);
        bus.req_valid[0] = 1'b0;
      end
      begin
        send1(1, 1'b1, 8'hA5, 1'b0);
        bus.req_valid[1] = 1'b0;
      end
    join
    wait_idle();

    // Back-to-back from requester 1: done and ready coincide
    do_reset();
    expect_cmd(1, 1'b0, 8'h48, 67, 0,  2'b10);
    expect_cmd(1, 1'b0, 8'h49, 67, 67, 2'b10);
    expect_cmd(1, 1'b0, 8'h4A, 67, 67, 2'b00);
    send1(1, 1'b0, 8'h48, 1'b0);
    send1(1, 1'b0, 8'h49, 1'b0);
    send1(1, 1'b0, 8'h4A, 1'b0);
    bus.req_valid[1] = 1'b0;
    wait_idle();

    repeat (5) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/tlcd_bus_arbiter.md
# tlcd_bus_arbiter

Command-level arbiter and bus sequencer for the shared 16x2 text LCD pins. It replaces the hard output mux between the custom font loader and the text LCD controller. Each requester hands over one byte-write command at a time through a valid/ready handshake. The arbiter grants the bus, generates the E strobe with the required setup, pulse and hold phases, waits out the LCD execution time, and pulses a per-requester done.

## Interface
Parameters:
- T_SETUP_CYC, 2: cycles RS/DATA are stable before E rises.
- T_E_HIGH_CYC, 12: E high width in cycles.
- T_HOLD_CYC, 2: cycles RS/DATA are held after E falls.
- T_EXEC_CYC, 50: LCD execution wait for ordinary commands and data writes.
- T_EXEC_LONG_CYC, 2000: execution wait for clear/home (RS=0 and DATA 8'h01 or 8'h02).

Ports:
- CLK  in  1  system clock; one clock domain.
- RESETN  in  1  asynchronous, active-low reset.
- req_valid  in  2  per-requester command valid; bit 0 is the font loader, bit 1 is the text controller.
- req_rs  in  2  per-requester RS value.
- req_data  in  16  per-requester DATA; [7:0] is requester 0, [15:8] is requester 1.
- req_lock  in  2  sampled with the accepted command; 1 keeps the bus reserved for that requester after this command.
- req_ready  out  2  accept strobe, one-hot or zero.
- req_done  out  2  one-cycle completion pulse to the owner.
- TLCD_E, TLCD_RS, TLCD_RW  out  1 each  LCD pins; TLCD_RW is always 0.
- TLCD_DATA  out  8  LCD data bus.
- busy  out  1  high in every state except IDLE.
- owner  out  1  index of the last granted requester.

## Operation
- State machine: IDLE → SETUP → E_HIGH → HOLD → EXEC → IDLE.
- IDLE, no lock held:
  - With a single valid requester, that requester wins.
  - With both valid, round-robin: the requester other than the last winner wins.
  - The last-winner register resets to 1, so requester 0 wins the first tie.
- IDLE, lock held by requester N:
  - Only req_valid[N] is considered.
  - The other requester waits indefinitely; this is not an error.
- req_ready[w] is combinational and asserts only in IDLE for the winner w. Acceptance means valid and ready are both high at a rising edge.
- On accept:
  - Capture RS, DATA and lock into internal registers; set owner to w.
  - Set the lock flag to the sampled lock bit.
  - Select the execution wait: the long wait when RS=0 and DATA is 8'h01 or 8'h02, otherwise T_EXEC_CYC.
- TLCD_RS and TLCD_DATA come from the captured registers in SETUP, E_HIGH and HOLD. They return to 0 in EXEC and IDLE.
- TLCD_E is high only in E_HIGH.
- On the EXEC→IDLE transition, req_done[owner] pulses for exactly one cycle. A new accept may occur in that same cycle (back-to-back).
- The phase counter is a single down-counter, width $clog2(max(all T_*)+1). It loads T-1 on entry to each phase; the phase exits when the counter reaches 0.
- A parameter value of 0 is illegal; checked by an elaboration assertion.
- Changes on req_* inputs after accept have no effect on the command in flight.
- Asynchronous reset, including mid-command:
  - All outputs are 0: E, RS, RW, DATA, ready, done, busy and owner.
  - State is IDLE, the lock flag is clear, and last winner is 1.
  - The aborted command is not resumed and no done is issued for it.

## Timing
- Accept at edge k: SETUP spans cycles k+1 to k+T_SETUP.
- E high spans k+T_SETUP+1 to k+T_SETUP+T_E_HIGH.
- HOLD spans the next T_HOLD cycles, then EXEC the next T_EXEC cycles.
- IDLE and the done pulse occur at k+T_SETUP+T_E_HIGH+T_HOLD+T_EXEC+1. With defaults this is k+67 for normal commands and k+2017 for long ones.
- Accept-to-accept minimum equals that figure.
- Zero latency from IDLE+valid to ready.

## Structure
- Package tlcd_pkg holds:
  - the state enum;
  - the is_long_cmd(rs, data) function;
  - default timing constants shared with the font loader and text controller.
- Sub-module lcd_phase_timer: loadable down-counter with a zero flag, instantiated once.
- Arbitration and the FSM stay in the top module.

## Test plan
- Single request: requester 0 sends RS=1, DATA=8'h41 with lock=0, accepted at edge k. Response: E high exactly cycles k+3 to k+14; DATA=8'h41 during k+1 to k+16; req_done[0] at k+67 only.
- Tie after reset: both valid. Response: requester 0 granted first, requester 1 at the done cycle, then requester 0 again. Grants strictly alternate.
- Lock: requester 0 sends 8 commands with lock=1 and then 1 with lock=0, while requester 1 is continuously valid. Response: requester 1 is first granted at the done of the 9th command.
- Long command: RS=0, DATA=8'h01. Response: done at k+2017. With RS=1 and DATA=8'h01, done at k+67.
- Mid-command reset: RESETN low during E_HIGH. Response: E, DATA and busy are 0 immediately without waiting for a clock edge; no req_done. After release, a new tie is granted to requester 0.
- Back-to-back: requester 1 holds valid continuously. Response: accepts at k, k+67 and k+134; req_done and req_ready both high at k+67.
